// File: rtl/morse_encoder.sv
// Morse transmitter: one ASCII character per valid/ready handshake, keyed out on key_out.
// Define MORSE_DIGITS_EN to add '0'-'9' to the character set.
module morse_encoder #(
  parameter logic [31:0] UNIT_CYCLES = 32'd6_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] letter,
  input  logic       letter_valid,
  output logic       letter_ready,
  output logic       key_out,
  output logic       busy,
  output logic       bad_char
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MARK       = 3'd1,
    ELEM_GAP   = 3'd2,
    LETTER_GAP = 3'd3,
    WORD       = 3'd4
  } stateT;

  // Returns {len[2:0], pat[4:0]}; the pattern is left-aligned (pat[4] is the first element).
  // A len of 0 marks an unsupported character.
  function automatic logic [7:0] lookupCode(input logic [7:0] ch);
    logic [7:0] up;
    logic [7:0] code;
    if (ch >= 8'h61 && ch <= 8'h7A) up = ch - 8'h20;
    else up = ch;
    case (up)
      8'h41: code = {3'd2, 5'b01000};  // A .-
      8'h42: code = {3'd4, 5'b10000};  // B -...
      8'h43: code = {3'd4, 5'b10100};  // C -.-.
      8'h44: code = {3'd3, 5'b10000};  // D -..
      8'h45: code = {3'd1, 5'b00000};  // E .
      8'h46: code = {3'd4, 5'b00100};  // F ..-.
      8'h47: code = {3'd3, 5'b11000};  // G --.
      8'h48: code = {3'd4, 5'b00000};  // H ....
      8'h49: code = {3'd2, 5'b00000};  // I ..
      8'h4A: code = {3'd4, 5'b01110};  // J .---
      8'h4B: code = {3'd3, 5'b10100};  // K -.-
      8'h4C: code = {3'd4, 5'b01000};  // L .-..
      8'h4D: code = {3'd2, 5'b11000};  // M --
      8'h4E: code = {3'd2, 5'b10000};  // N -.
      8'h4F: code = {3'd3, 5'b11100};  // O ---
      8'h50: code = {3'd4, 5'b01100};  // P .--.
      8'h51: code = {3'd4, 5'b11010};  // Q --.-
      8'h52: code = {3'd3, 5'b01000};  // R .-.
      8'h53: code = {3'd3, 5'b00000};  // S ...
      8'h54: code = {3'd1, 5'b10000};  // T -
      8'h55: code = {3'd3, 5'b00100};  // U ..-
      8'h56: code = {3'd4, 5'b00010};  // V ...-
      8'h57: code = {3'd3, 5'b01100};  // W .--
      8'h58: code = {3'd4, 5'b10010};  // X -..-
      8'h59: code = {3'd4, 5'b10110};  // Y -.--
      8'h5A: code = {3'd4, 5'b11000};  // Z --..
`ifdef MORSE_DIGITS_EN
      8'h30: code = {3'd5, 5'b11111};
      8'h31: code = {3'd5, 5'b01111};
      8'h32: code = {3'd5, 5'b00111};
      8'h33: code = {3'd5, 5'b00011};
      8'h34: code = {3'd5, 5'b00001};
      8'h35: code = {3'd5, 5'b00000};
      8'h36: code = {3'd5, 5'b10000};
      8'h37: code = {3'd5, 5'b11000};
      8'h38: code = {3'd5, 5'b11100};
      8'h39: code = {3'd5, 5'b11110};
`endif
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  stateT       stateR, stateNext;
  logic [31:0] unitCycleR;
  logic [1:0]  unitNumR;
  logic [2:0]  elemIdxR;
  logic [2:0]  lenR;
  logic [4:0]  patR;
  logic        keyOutR, busyR, readyR, badCharR;

  logic [7:0]  codeS;
  logic [2:0]  lenS;
  logic [4:0]  patS;
  logic        curDashS, unitEndS, phaseDoneS, lastElemS, loadS, badS;
  logic [1:0]  lastUnitS;

  assign codeS      = lookupCode(letter);
  assign lenS       = codeS[7:5];
  assign patS       = codeS[4:0];
  assign curDashS   = patR[3'd4 - elemIdxR];
  assign unitEndS   = (unitCycleR == UNIT_CYCLES - 32'd1);
  assign phaseDoneS = unitEndS && (unitNumR == lastUnitS);
  assign lastElemS  = (elemIdxR == lenR - 3'd1);

  // Index of the final unit of the current phase (unit count minus one).
  always_comb begin
    lastUnitS = 2'd0;
    case (stateR)
      MARK:       lastUnitS = curDashS ? 2'd2 : 2'd0;
      ELEM_GAP:   lastUnitS = 2'd0;
      LETTER_GAP: lastUnitS = 2'd2;
      WORD:       lastUnitS = 2'd3;
      default:    lastUnitS = 2'd0;
    endcase
  end

  // Next-state logic, code load and unsupported-character detection.
  always_comb begin
    stateNext = stateR;
    loadS     = 1'b0;
    badS      = 1'b0;
    case (stateR)
      IDLE: begin
        if (letter_valid) begin
          if (letter == 8'h20) begin
            stateNext = WORD;
          end else if (lenS != 3'd0) begin
            stateNext = MARK;
            loadS     = 1'b1;
          end else begin
            badS = 1'b1;
          end
        end else begin
          stateNext = IDLE;
        end
      end
      MARK: begin
        if (phaseDoneS) stateNext = lastElemS ? LETTER_GAP : ELEM_GAP;
        else stateNext = MARK;
      end
      ELEM_GAP: begin
        if (phaseDoneS) stateNext = MARK;
        else stateNext = ELEM_GAP;
      end
      LETTER_GAP, WORD: begin
        if (phaseDoneS) stateNext = IDLE;
        else stateNext = stateR;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, counters and registered outputs; counters restart on every phase change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR     <= IDLE;
      unitCycleR <= 32'd0;
      unitNumR   <= 2'd0;
      elemIdxR   <= 3'd0;
      lenR       <= 3'd0;
      patR       <= 5'd0;
      keyOutR    <= 1'b0;
      busyR      <= 1'b0;
      readyR     <= 1'b1;
      badCharR   <= 1'b0;
    end else begin
      stateR <= stateNext;
      if (loadS) begin
        lenR <= lenS;
        patR <= patS;
      end
      if (stateR == IDLE || phaseDoneS) begin
        unitCycleR <= 32'd0;
        unitNumR   <= 2'd0;
      end else if (unitEndS) begin
        unitCycleR <= 32'd0;
        unitNumR   <= unitNumR + 2'd1;
      end else begin
        unitCycleR <= unitCycleR + 32'd1;
      end
      if (stateR == IDLE) elemIdxR <= 3'd0;
      else if (stateR == ELEM_GAP && phaseDoneS) elemIdxR <= elemIdxR + 3'd1;
      keyOutR  <= (stateNext == MARK);
      busyR    <= (stateNext != IDLE);
      readyR   <= (stateNext == IDLE);
      badCharR <= badS;
    end
  end

  assign key_out      = keyOutR;
  assign busy         = busyR;
  assign letter_ready = readyR;
  assign bad_char     = badCharR;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: instances with UNIT_CYCLES 4 and 1, checked cycle by cycle
// against a waveform built from Morse strings.
module tb_morse_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] letterIn [2];
  logic       validIn  [2];
  logic       readyOut [2];
  logic       keyOut   [2];
  logic       busyOut  [2];
  logic       badOut   [2];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  morse_encoder #(.UNIT_CYCLES(32'd4)) dut4 (
    .clk(clk), .reset(reset), .letter(letterIn[0]), .letter_valid(validIn[0]),
    .letter_ready(readyOut[0]), .key_out(keyOut[0]), .busy(busyOut[0]), .bad_char(badOut[0])
  );

  morse_encoder #(.UNIT_CYCLES(32'd1)) dut1 (
    .clk(clk), .reset(reset), .letter(letterIn[1]), .letter_valid(validIn[1]),
    .letter_ready(readyOut[1]), .key_out(keyOut[1]), .busy(busyOut[1]), .bad_char(badOut[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string morseOf(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
`ifdef MORSE_DIGITS_EN
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
`endif
      default: return "";
    endcase
  endfunction

  // Called at a negedge with the instance idle; returns at the negedge where it is idle again.
  task automatic sendAndCheck(input int s, input logic [7:0] c);
    string code;
    int    uc;
    int    nu;
    bit    expKey[$];
    uc   = (s == 0) ? 4 : 1;
    code = morseOf(c);
    if (c == 8'h20) begin
      repeat (4 * uc) expKey.push_back(1'b0);
    end else begin
      for (int k = 0; k < code.len(); k++) begin
        nu = (code[k] == 8'h2D) ? 3 : 1;
        repeat (nu * uc) expKey.push_back(1'b1);
        repeat (((k == code.len() - 1) ? 3 : 1) * uc) expKey.push_back(1'b0);
      end
    end
    chk("ready_before_accept", 32'(readyOut[s]), 32'd1);
    letterIn[s] = c;
    validIn[s]  = 1'b1;
    @(negedge clk);
    if (expKey.size() == 0) begin
      validIn[s]  = 1'b0;
      letterIn[s] = 8'($urandom);
      chk("bad_pulse", 32'(badOut[s]), 32'd1);
      chk("bad_key", 32'(keyOut[s]), 32'd0);
      chk("bad_ready", 32'(readyOut[s]), 32'd1);
      @(negedge clk);
      chk("bad_one_cycle", 32'(badOut[s]), 32'd0);
      chk("bad_ready_after", 32'(readyOut[s]), 32'd1);
    end else begin
      foreach (expKey[i]) begin
        // Garbage on the inputs while busy must be ignored.
        letterIn[s] = 8'($urandom);
        validIn[s]  = 1'($urandom);
        chk($sformatf("key_%0d_c%0d", s, i + 1), 32'(keyOut[s]), 32'(expKey[i]));
        chk("busy_high", 32'(busyOut[s]), 32'd1);
        chk("ready_low", 32'(readyOut[s]), 32'd0);
        chk("no_bad", 32'(badOut[s]), 32'd0);
        @(negedge clk);
      end
      chk($sformatf("ready_back_%0d", expKey.size() + 1), 32'(readyOut[s]), 32'd1);
      chk("busy_low_end", 32'(busyOut[s]), 32'd0);
      chk("key_low_end", 32'(keyOut[s]), 32'd0);
    end
    validIn[s] = 1'b0;
  endtask

  function automatic logic [7:0] randChar();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 8'(8'h41 + $urandom_range(0, 25));
    else if (r <= 7) return 8'(8'h61 + $urandom_range(0, 25));
    else if (r == 8) return 8'h20;
    else return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    letterIn[0] = 8'h00; letterIn[1] = 8'h00;
    validIn[0]  = 1'b0;  validIn[1]  = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_key", 32'(keyOut[s]), 32'd0);
      chk("rst_busy", 32'(busyOut[s]), 32'd0);
      chk("rst_bad", 32'(badOut[s]), 32'd0);
      chk("rst_ready", 32'(readyOut[s]), 32'd1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    sendAndCheck(0, "E");
    sendAndCheck(0, "A");
    sendAndCheck(0, "T");
    sendAndCheck(0, " ");
    sendAndCheck(0, "#");
    sendAndCheck(0, "5");
    sendAndCheck(0, "0");
    sendAndCheck(1, "q");
    sendAndCheck(1, "E");

    // Reset in the middle of the first dash of 'O' must drop key_out without a clock edge.
    letterIn[0] = "O";
    validIn[0]  = 1'b1;
    @(negedge clk);
    validIn[0] = 1'b0;
    @(negedge clk);
    chk("o_dash_key", 32'(keyOut[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midreset_key", 32'(keyOut[0]), 32'd0);
    chk("midreset_ready", 32'(readyOut[0]), 32'd1);
    chk("midreset_busy", 32'(busyOut[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sendAndCheck(0, "E");

    for (int n = 0; n < 12; n++) begin
      sendAndCheck(0, randChar());
      sendAndCheck(1, randChar());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
